// File: rtl/chromosome_evaluator.sv
// chromosome_evaluator: steps a phenotype circuit through stored samples, accumulating
// per-output-bit error counts across retry passes. Trace log: define CHROM_EVAL_TRACE_LOG_EN.
module chromosome_evaluator #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 8,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    parameter int SETTLE     = 4,
    parameter int LOG_ADDR_W = 15
) (
    input  logic                          iClock,
    input  logic                          iResetN,
    input  logic                          iStart,
    input  logic                          iAck,
    input  logic [ADDR_W-1:0]             iNumSamples,
    input  logic [CNT_W-1:0]              iHoldCycles,
    input  logic [3:0]                    iRetries,
    input  logic                          iForceInput,
    input  logic [IN_W-1:0]               iForcedInput,
    output logic [ADDR_W-1:0]             oSampleAddr,
    input  logic [IN_W-1:0]               iSampleIn,
    input  logic [OUT_W-1:0]              iSampleExp,
    input  logic [OUT_W-1:0]              iSampleMask,
    output logic [IN_W-1:0]               oCircuitIn,
    output logic                          oCircuitClear,
    input  logic [OUT_W-1:0]              iCircuitOut,
    output logic                          oReady,
    output logic                          oDone,
    output logic                          oPass,
    output logic [2:0]                    oState,
    output logic [OUT_W*CNT_W-1:0]        oErrorCounts,
    output logic [CNT_W+$clog2(OUT_W):0]  oErrorTotal
`ifdef CHROM_EVAL_TRACE_LOG_EN
    ,
    output logic                          oLogWrite,
    output logic [LOG_ADDR_W-1:0]         oLogAddr,
    output logic [IN_W+ADDR_W+2*OUT_W-1:0] oLogData,
    output logic                          oLogFull
`endif
);

    // Handshake: iStart is taken only while oReady (IDLE); the result is held while oDone
    // until iAck, which wins over a simultaneous iStart.

    localparam int SUM_W  = CNT_W + $clog2(OUT_W) + 1;
    // The hold counter must reach SETTLE even when CNT_W is narrower than that.
    localparam int HOLD_W = (CNT_W > $clog2(SETTLE + 2)) ? CNT_W : $clog2(SETTLE + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        APPLY = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       index;
    logic [ADDR_W-1:0]       lastIndex;
    logic [HOLD_W-1:0]       holdCnt;
    logic [HOLD_W-1:0]       holdLast;
    logic [HOLD_W-1:0]       holdReq;
    logic [HOLD_W-1:0]       holdMin;
    logic [HOLD_W-1:0]       holdEff;
    logic [3:0]              retry;
    logic [3:0]              retryLimit;
    logic [OUT_W-1:0]        expReg;
    logic [OUT_W-1:0]        maskReg;
    logic [OUT_W-1:0]        flags;
    logic [OUT_W-1:0]        mismatch;
    logic [OUT_W-1:0]        hits;
    logic [OUT_W*CNT_W-1:0]  errCounts;
    logic [OUT_W*CNT_W-1:0]  nextCounts;
    logic [SUM_W-1:0]        errTotal;
    logic                    settled;
    logic                    lastCycle;

    assign holdReq   = HOLD_W'(iHoldCycles);
    assign holdMin   = HOLD_W'(SETTLE + 1);
    assign holdEff   = (holdReq > holdMin) ? holdReq : holdMin;
    assign mismatch  = (iCircuitOut ^ expReg) & maskReg;
    assign settled   = holdCnt >= HOLD_W'(SETTLE);
    assign lastCycle = holdCnt == holdLast;
    assign hits      = flags | (settled ? mismatch : '0);

    // Saturating increment of every bit that mismatched in this hold window.
    always_comb begin
        errTotal   = '0;
        nextCounts = errCounts;
        for (int i = 0; i < OUT_W; i++) begin
            errTotal = errTotal + SUM_W'(errCounts[i*CNT_W +: CNT_W]);
            if (hits[i] && (errCounts[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
                nextCounts[i*CNT_W +: CNT_W] = errCounts[i*CNT_W +: CNT_W] + 1'b1;
        end
    end

    assign oSampleAddr  = index;
    assign oErrorCounts = errCounts;
    assign oErrorTotal  = errTotal;
    assign oState       = state;

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state         <= IDLE;
            index         <= '0;
            lastIndex     <= '0;
            holdCnt       <= '0;
            holdLast      <= '0;
            retry         <= '0;
            retryLimit    <= '0;
            expReg        <= '0;
            maskReg       <= '0;
            flags         <= '0;
            errCounts     <= '0;
            oCircuitIn    <= '0;
            oCircuitClear <= 1'b0;
            oReady        <= 1'b1;
            oDone         <= 1'b0;
            oPass         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        lastIndex     <= (iNumSamples == '0) ? '0 : iNumSamples - 1'b1;
                        holdLast      <= holdEff - 1'b1;
                        retryLimit    <= iRetries;
                        errCounts     <= '0;
                        index         <= '0;
                        retry         <= '0;
                        oPass         <= 1'b0;
                        oReady        <= 1'b0;
                        oCircuitClear <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    oCircuitClear <= 1'b0;
                    state         <= FETCH;
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    oCircuitIn <= iForceInput ? iForcedInput : iSampleIn;
                    expReg     <= iSampleExp;
                    maskReg    <= iSampleMask;
                    flags      <= '0;
                    holdCnt    <= '0;
                    state      <= APPLY;
                end
                APPLY: begin
                    flags <= hits;
                    if (lastCycle) begin
                        errCounts <= nextCounts;
                        if (index == lastIndex) begin
                            state <= CHECK;
                        end else begin
                            index <= index + 1'b1;
                            state <= FETCH;
                        end
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (errTotal != '0) begin
                        oPass <= 1'b0;
                        oDone <= 1'b1;
                        state <= DONE;
                    end else if (retry == retryLimit) begin
                        oPass <= 1'b1;
                        oDone <= 1'b1;
                        state <= DONE;
                    end else begin
                        retry <= retry + 1'b1;
                        index <= '0;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (iAck) begin
                        oDone  <= 1'b0;
                        oPass  <= 1'b0;
                        oReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CHROM_EVAL_TRACE_LOG_EN
    logic [LOG_ADDR_W-1:0] logAddr;
    logic                  logFull;
    logic                  newPass;

    assign newPass   = (state == CLEAR) ||
                       ((state == CHECK) && (errTotal == '0) && (retry != retryLimit));
    assign oLogWrite = (state == APPLY) && !logFull;
    assign oLogAddr  = logAddr;
    assign oLogFull  = logFull;
    assign oLogData  = {oCircuitIn, index, expReg, iCircuitOut};

    // The last address is written once, then the log freezes until the next pass.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            logAddr <= '0;
            logFull <= 1'b0;
        end else if (newPass) begin
            logAddr <= '0;
            logFull <= 1'b0;
        end else if (oLogWrite) begin
            if (logAddr == {LOG_ADDR_W{1'b1}})
                logFull <= 1'b1;
            else
                logAddr <= logAddr + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_chromosome_evaluator.sv
// Self-checking bench for chromosome_evaluator: sample memory and phenotype models,
// scoreboard of expected run results, and a CNT_W=2 instance for saturation.
module tb_chromosome_evaluator;

  localparam int SETTLE = 4;
  localparam int EXP_W  = 165;  // {cycles[15:0], pass, total[19:0], counts[127:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, ack, force_in;
  logic [7:0]  num, forced_in;
  logic [15:0] hold;
  logic [3:0]  retries;
  logic [7:0]  sample_addr, rd_in, rd_exp, rd_mask, circ_in, circ_out;
  logic        circ_clear, ready, done, pass;
  logic [2:0]  state;
  logic [127:0] counts;
  logic [19:0] total;

  logic        sat_start, sat_ack;
  logic [7:0]  sat_addr, sat_rd_in, sat_rd_exp, sat_rd_mask, sat_circ_in, sat_circ_out;
  logic        sat_clear, sat_ready, sat_done, sat_pass;
  logic [2:0]  sat_state;
  logic [15:0] sat_counts;
  logic [5:0]  sat_total;

`ifdef CHROM_EVAL_TRACE_LOG_EN
  logic        log_write, log_full, sat_log_write, sat_log_full;
  logic [3:0]  log_addr;
  logic [14:0] sat_log_addr;
  logic [31:0] log_data, sat_log_data;
`endif

  logic [7:0] mem_in   [0:255];
  logic [7:0] mem_exp  [0:255];
  logic [7:0] mem_mask [0:255];

  logic [7:0] err_pat;
  bit         glitch_en;
  int         glitch_at, glitch_idx, apply_cnt, log_writes;
  int         checks, errors;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [7:0] golden(input logic [7:0] x);
    return {x[3:0], x[7:4]} ^ 8'h3C;
  endfunction

  always @(posedge clk) begin
    rd_in       <= mem_in[sample_addr];
    rd_exp      <= mem_exp[sample_addr];
    rd_mask     <= mem_mask[sample_addr];
    sat_rd_in   <= mem_in[sat_addr];
    sat_rd_exp  <= mem_exp[sat_addr];
    sat_rd_mask <= mem_mask[sat_addr];
    apply_cnt   <= (state == 3'd4) ? apply_cnt + 1 : 0;
  end

  assign circ_out = golden(circ_in) ^ err_pat ^
                    ((glitch_en && state == 3'd4 && apply_cnt == glitch_at &&
                      sample_addr == 8'(glitch_idx)) ? 8'h20 : 8'h00);
  assign sat_circ_out = golden(sat_circ_in) ^ 8'h01;

  chromosome_evaluator #(.LOG_ADDR_W(4)) dut (
    .iClock(clk), .iResetN(rst_n), .iStart(start), .iAck(ack),
    .iNumSamples(num), .iHoldCycles(hold), .iRetries(retries),
    .iForceInput(force_in), .iForcedInput(forced_in), .oSampleAddr(sample_addr),
    .iSampleIn(rd_in), .iSampleExp(rd_exp), .iSampleMask(rd_mask),
    .oCircuitIn(circ_in), .oCircuitClear(circ_clear), .iCircuitOut(circ_out),
    .oReady(ready), .oDone(done), .oPass(pass), .oState(state),
    .oErrorCounts(counts), .oErrorTotal(total)
`ifdef CHROM_EVAL_TRACE_LOG_EN
    , .oLogWrite(log_write), .oLogAddr(log_addr), .oLogData(log_data), .oLogFull(log_full)
`endif
  );

  chromosome_evaluator #(.CNT_W(2)) dut_sat (
    .iClock(clk), .iResetN(rst_n), .iStart(sat_start), .iAck(sat_ack),
    .iNumSamples(8'd6), .iHoldCycles(2'd3), .iRetries(4'd0),
    .iForceInput(1'b0), .iForcedInput(8'h00), .oSampleAddr(sat_addr),
    .iSampleIn(sat_rd_in), .iSampleExp(sat_rd_exp), .iSampleMask(sat_rd_mask),
    .oCircuitIn(sat_circ_in), .oCircuitClear(sat_clear), .iCircuitOut(sat_circ_out),
    .oReady(sat_ready), .oDone(sat_done), .oPass(sat_pass), .oState(sat_state),
    .oErrorCounts(sat_counts), .oErrorTotal(sat_total)
`ifdef CHROM_EVAL_TRACE_LOG_EN
    , .oLogWrite(sat_log_write), .oLogAddr(sat_log_addr), .oLogData(sat_log_data),
    .oLogFull(sat_log_full)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  // Behavioural reference: walks passes, samples and hold cycles directly.
  function automatic logic [EXP_W-1:0] model(input int n, input int h, input int r,
      input logic [7:0] err, input logic [7:0] msk, input bit gen, input int gat,
      input int gidx, input int cmax);
    int ne, he, passes, tot;
    int cnt [8];
    bit ok;
    logic [127:0] cv;
    ne = (n == 0) ? 1 : n;
    he = (h < SETTLE + 1) ? SETTLE + 1 : h;
    passes = 0;
    ok = 1'b0;
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    for (int p = 0; p <= r; p++) begin
      passes++;
      for (int s = 0; s < ne; s++) begin
        for (int b = 0; b < 8; b++) begin
          bit flag;
          flag = 1'b0;
          for (int c = 0; c < he; c++) begin
            logic [7:0] e;
            e = err ^ ((gen && s == gidx && c == gat) ? 8'h20 : 8'h00);
            if (c >= SETTLE && e[b] && msk[b]) flag = 1'b1;
          end
          if (flag && cnt[b] < cmax) cnt[b]++;
        end
      end
      tot = 0;
      for (int b = 0; b < 8; b++) tot += cnt[b];
      if (tot != 0) break;
      if (p == r) ok = 1'b1;
    end
    cv = '0;
    for (int b = 0; b < 8; b++) cv[b*16 +: 16] = 16'(cnt[b]);
    return {16'(1 + passes * ne * (he + 2) + passes), ok, 20'(tot), cv};
  endfunction

  task automatic fill_mem(input logic [7:0] msk);
    for (int s = 0; s < 256; s++) begin
      mem_in[s]   = 8'($urandom_range(0, 255));
      mem_exp[s]  = golden(mem_in[s]);
      mem_mask[s] = msk;
    end
  endtask

  task automatic run_eval(input int n, input int h, input int r, input logic [7:0] err,
      input logic [7:0] msk, input bit gen, input int gat, input int gidx, input bit frc,
      input bit ack_start);
    logic [EXP_W-1:0] e;
    int cyc;
    fill_mem(msk);
    err_pat = err; glitch_en = gen; glitch_at = gat; glitch_idx = gidx;
    force_in = frc; forced_in = 8'hA5;
    exp_q.push_back(model(n, h, r, err, msk, gen, gat, gidx, 65535));
    num = 8'(n); hold = 16'(h); retries = 4'(r); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0; log_writes = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 3) check("first_in", 128'(circ_in), 128'(frc ? 8'hA5 : mem_in[0]));
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
`ifdef CHROM_EVAL_TRACE_LOG_EN
      if (log_write) log_writes++;
`endif
    end
    check("done_seen", 128'(done), 128'(1));
    e = exp_q.pop_front();
    check("cycles", 128'(cyc), 128'(e[164:149]));
    check("pass", 128'(pass), 128'(e[148]));
    check("total", 128'(total), 128'(e[147:128]));
    check("counts", counts, e[127:0]);
    ack = 1'b1;
    if (ack_start) start = 1'b1;
    @(posedge clk); #1; ack = 1'b0; start = 1'b0;
    check("ack_idle", 128'(state), 128'(0));
    if (ack_start) begin
      @(posedge clk); #1;
      check("start_with_ack_ignored", 128'(state), 128'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [EXP_W-1:0] e;
    int cyc;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; num = '0; hold = '0; retries = '0;
    force_in = 1'b0; forced_in = '0; sat_start = 1'b0; sat_ack = 1'b0;
    err_pat = '0; glitch_en = 1'b0; glitch_at = 0; glitch_idx = 0; log_writes = 0;
    fill_mem(8'hFF);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 128'(ready), 128'(1));
    check("rst_state", 128'(state), 128'(0));
    check("rst_total", 128'(total), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_circ_in", 128'(circ_in), 128'(0));

    // perfect circuit, glitch inside and outside the settle window, masking, steady errors
    run_eval(3, 10, 2, 8'h00, 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    run_eval(3, 10, 1, 8'h00, 8'hFF, 1'b1, 2, 1, 1'b0, 1'b0);
    run_eval(3, 10, 2, 8'h00, 8'hFF, 1'b1, 9, 1, 1'b0, 1'b1);
    run_eval(5, 6, 1, 8'hF0, 8'h0F, 1'b0, 0, 0, 1'b0, 1'b0);
    run_eval(4, 7, 3, 8'h81, 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    run_eval(0, 2, 0, 8'h00, 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    run_eval(1, 5, 0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      run_eval($urandom_range(1, 6), $urandom_range(0, 12), $urandom_range(0, 3),
               $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'h00,
               8'($urandom_range(0, 255)), 1'b0, 0, 0, 1'b0, 1'b0);

`ifdef CHROM_EVAL_TRACE_LOG_EN
    run_eval(2, 10, 0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0);
    check("log_writes", 128'(log_writes), 128'(16));
    check("log_full", 128'(log_full), 128'(1));
    check("log_addr", 128'(log_addr), 128'(15));
`endif

    // asynchronous reset in the middle of the second sample's hold window
    fill_mem(8'hFF);
    err_pat = 8'hFF; glitch_en = 1'b0; force_in = 1'b0;
    num = 8'd4; hold = 16'd10; retries = 4'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_state", 128'(state), 128'(4));
    check("mid_total", 128'(total), 128'(8));
    #2; rst_n = 1'b0; #1;
    check("arst_ready", 128'(ready), 128'(1));
    check("arst_state", 128'(state), 128'(0));
    check("arst_total", 128'(total), 128'(0));
    check("arst_circ_in", 128'(circ_in), 128'(0));
    @(posedge clk); #1; rst_n = 1'b1; err_pat = 8'h00;

    // CNT_W=2 instance: bit 0 wrong on every sample saturates at 3
    fill_mem(8'hFF);
    exp_q.push_back(model(6, 3, 0, 8'h01, 8'hFF, 1'b0, 0, 0, 3));
    sat_start = 1'b1;
    @(posedge clk); #1; sat_start = 1'b0;
    cyc = 0;
    while (!sat_done && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    e = exp_q.pop_front();
    check("sat_cycles", 128'(cyc), 128'(e[164:149]));
    check("sat_pass", 128'(sat_pass), 128'(e[148]));
    check("sat_total", 128'(sat_total), 128'(e[147:128]));
    check("sat_count0", 128'(sat_counts[1:0]), 128'(e[15:0]));
    sat_ack = 1'b1;
    @(posedge clk); #1; sat_ack = 1'b0;
    check("sat_idle", 128'(sat_state), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
